// File: rtl/mf8_pcseq.sv
// mf8_pcseq: program-counter sequencer for the mf8 core.
// Chooses the next fetch address from return, call, absolute jump, relative
// jump and increment requests. Return addresses live in a small circular
// register stack. Depth and sticky overflow/underflow flags are reported
// to the status logic.
module mf8_pcseq #(
    parameter int                    PC_WIDTH     = 12,
    parameter int                    STACK_DEPTH  = 4,
    parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = '0,
    localparam int                   DEPTH_W      = $clog2(STACK_DEPTH) + 1
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Pause,
    input  logic                RJmp,
    input  logic                AJmp,
    input  logic                Call,
    input  logic                Ret,
    input  logic                Flag_Clr,
    input  logic [PC_WIDTH-1:0] Offs_In,
    input  logic [PC_WIDTH-1:0] Abs_In,
    output logic [PC_WIDTH-1:0] NPC,
    output logic [PC_WIDTH-1:0] PC,
    output logic [PC_WIDTH-1:0] Top,
    output logic [DEPTH_W-1:0]  Depth,
    output logic                Stk_Ovf,
    output logic                Stk_Unf
);

    localparam int                 PTR_W     = $clog2(STACK_DEPTH);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

    // Architectural state
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [DEPTH_W-1:0]  depth_q, depth_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];
    logic [PC_WIDTH-1:0] stack_d [STACK_DEPTH];

    // Derived values
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] pc_rel;
    logic [PC_WIDTH-1:0] call_tgt;
    logic [PC_WIDTH-1:0] top_val;
    logic [PTR_W-1:0]    top_ptr;
    logic                stack_empty;
    logic                stack_full;
    logic                do_push;
    logic                do_pop;

    // Address arithmetic and stack occupancy decode.
    // The adders are PC_WIDTH wide, so wrap in both directions is implicit.
    always_comb begin
        pc_inc      = pc_q + PC_WIDTH'(1);
        pc_rel      = pc_q + Offs_In;
        call_tgt    = AJmp ? Abs_In : pc_rel;
        top_ptr     = wr_ptr_q - PTR_W'(1);
        stack_empty = (depth_q == '0);
        stack_full  = (depth_q == DEPTH_MAX);
        top_val     = stack_empty ? '0 : stack_q[top_ptr];
        // Ret dominates Call. A simultaneous Call is dropped entirely.
        do_pop      = Ret;
        do_push     = Call & ~Ret;
    end

    // Next-PC priority select: Ret, Call, AJmp, RJmp, then increment.
    // Pause only suppresses the increment.
    always_comb begin
        if (Ret) begin
            pc_d = stack_empty ? RESET_VECTOR : top_val;
        end else if (Call) begin
            pc_d = call_tgt;
        end else if (AJmp) begin
            pc_d = Abs_In;
        end else if (RJmp) begin
            pc_d = pc_rel;
        end else if (Pause) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_inc;
        end
    end

    // Return-stack pointer, occupancy and entry writes.
    // When the stack is full, a push overwrites the oldest slot. The write
    // pointer already addresses that slot because the buffer is circular.
    always_comb begin
        stack_d  = stack_q;
        wr_ptr_d = wr_ptr_q;
        depth_d  = depth_q;
        if (do_push) begin
            stack_d[wr_ptr_q] = pc_inc;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
            if (!stack_full) begin
                depth_d = depth_q + DEPTH_W'(1);
            end
        end else if (do_pop && !stack_empty) begin
            wr_ptr_d = top_ptr;
            depth_d  = depth_q - DEPTH_W'(1);
        end
    end

    // Sticky error flags. A set event in the same cycle outranks Flag_Clr.
    always_comb begin
        ovf_d = (ovf_q & ~Flag_Clr) | (do_push & stack_full);
        unf_d = (unf_q & ~Flag_Clr) | (do_pop & stack_empty);
    end

    // State registers. Reset also zeroes the stack so that Top is
    // deterministic and no stale return address survives.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_q     <= RESET_VECTOR;
            wr_ptr_q <= '0;
            depth_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            depth_q  <= depth_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= stack_d[i];
            end
        end
    end

    // Output mapping
    always_comb begin
        NPC     = pc_d;
        PC      = pc_q;
        Top     = top_val;
        Depth   = depth_q;
        Stk_Ovf = ovf_q;
        Stk_Unf = unf_q;
    end

endmodule

// File: tb/tb_mf8_pcseq.sv
// Self-checking bench for mf8_pcseq.
// The reference model keeps the return stack as a queue with its own PC and
// flags. The bench first runs the directed sequences, then random traffic.
module tb_mf8_pcseq;

    localparam int PCW   = 12;
    localparam int SD    = 4;
    localparam int DW    = $clog2(SD) + 1;
    localparam int MASK  = (1 << PCW) - 1;
    localparam int RV    = 0;

    logic           Clk = 1'b0;
    logic           Reset = 1'b1;
    logic           Pause = 1'b0, RJmp = 1'b0, AJmp = 1'b0, Call = 1'b0, Ret = 1'b0, Flag_Clr = 1'b0;
    logic [PCW-1:0] Offs_In = '0, Abs_In = '0;
    logic [PCW-1:0] NPC, PC, Top;
    logic [DW-1:0]  Depth;
    logic           Stk_Ovf, Stk_Unf;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_pc;
    int m_stk[$];
    bit m_ovf, m_unf;

    mf8_pcseq #(.PC_WIDTH(PCW), .STACK_DEPTH(SD), .RESET_VECTOR(PCW'(RV))) dut (
        .Clk(Clk), .Reset(Reset), .Pause(Pause), .RJmp(RJmp), .AJmp(AJmp),
        .Call(Call), .Ret(Ret), .Flag_Clr(Flag_Clr), .Offs_In(Offs_In),
        .Abs_In(Abs_In), .NPC(NPC), .PC(PC), .Top(Top), .Depth(Depth),
        .Stk_Ovf(Stk_Ovf), .Stk_Unf(Stk_Unf)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_npc();
        if (Ret)       return (m_stk.size() > 0) ? m_stk[$] : RV;
        if (Call)      return AJmp ? int'(Abs_In) : ((m_pc + int'(Offs_In)) & MASK);
        if (AJmp)      return int'(Abs_In);
        if (RJmp)      return (m_pc + int'(Offs_In)) & MASK;
        return (m_pc + (Pause ? 0 : 1)) & MASK;
    endfunction

    task automatic model_reset();
        m_pc = RV;
        m_stk.delete();
        m_ovf = 0;
        m_unf = 0;
    endtask

    task automatic model_clock();
        int  nxt;
        bit  set_ovf, set_unf;
        nxt = model_npc();
        set_ovf = 0;
        set_unf = 0;
        if (Ret) begin
            if (m_stk.size() > 0) void'(m_stk.pop_back());
            else set_unf = 1;
        end else if (Call) begin
            if (m_stk.size() == SD) begin
                void'(m_stk.pop_front());
                set_ovf = 1;
            end
            m_stk.push_back((m_pc + 1) & MASK);
        end
        m_ovf = set_ovf | (m_ovf & ~Flag_Clr);
        m_unf = set_unf | (m_unf & ~Flag_Clr);
        m_pc  = nxt;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".pc"},    32'(PC),      32'(m_pc));
        chk({tag, ".depth"}, 32'(Depth),   32'(m_stk.size()));
        chk({tag, ".top"},   32'(Top),     (m_stk.size() > 0) ? 32'(m_stk[$]) : 32'd0);
        chk({tag, ".ovf"},   32'(Stk_Ovf), 32'(m_ovf));
        chk({tag, ".unf"},   32'(Stk_Unf), 32'(m_unf));
    endtask

    // One cycle: apply controls, check NPC mid-cycle, clock, check state.
    task automatic step(input string tag, input bit ret, input bit call, input bit aj,
                        input bit rj, input bit ps, input bit clr,
                        input int offs, input int abs_t);
        Ret = ret; Call = call; AJmp = aj; RJmp = rj; Pause = ps; Flag_Clr = clr;
        Offs_In = PCW'(offs); Abs_In = PCW'(abs_t);
        #1;
        chk({tag, ".npc"}, 32'(NPC), 32'(model_npc()));
        @(posedge Clk);
        model_clock();
        #1;
        check_state(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_state("reset");
        Reset = 1'b0;

        // Increment, pause, relative jump backwards under pause
        for (int i = 0; i < 5; i++) idle("inc");
        chk("plan.pc5", 32'(PC), 32'h5);
        step("pause", 0, 0, 0, 0, 1, 0, 0, 0);
        step("pause", 0, 0, 0, 0, 1, 0, 0, 0);
        chk("plan.pause_hold", 32'(PC), 32'h5);
        step("rjmp_back", 0, 0, 0, 1, 1, 0, 'hFFE, 0);
        chk("plan.rjmp_back", 32'(PC), 32'h3);

        // Wrap in both directions
        step("aj_fff", 0, 0, 1, 0, 0, 0, 0, 'hFFF);
        idle("wrap_up");
        chk("plan.wrap_up", 32'(PC), 32'h0);
        step("aj_010", 0, 0, 1, 0, 0, 0, 0, 'h010);
        step("rj_ff0", 0, 0, 0, 1, 0, 0, 'hFF0, 0);
        chk("plan.wrap_rel", 32'(PC), 32'h0);

        // Nested calls and returns
        step("aj_100", 0, 0, 1, 0, 0, 0, 0, 'h100);
        step("call_abs", 0, 1, 1, 0, 0, 0, 0, 'h200);
        chk("plan.call1_pc", 32'(PC), 32'h200);
        chk("plan.call1_top", 32'(Top), 32'h101);
        step("call_rel", 0, 1, 0, 1, 0, 0, 'h010, 0);
        chk("plan.call2_pc", 32'(PC), 32'h210);
        chk("plan.call2_depth", 32'(Depth), 32'd2);
        step("ret1", 1, 0, 0, 0, 0, 0, 0, 0);
        chk("plan.ret1", 32'(PC), 32'h201);
        step("ret2", 1, 0, 0, 0, 0, 0, 0, 0);
        chk("plan.ret2", 32'(PC), 32'h101);
        chk("plan.ret2_depth", 32'(Depth), 32'd0);

        // Overflow: five calls into a four-deep stack
        step("aj_10", 0, 0, 1, 0, 0, 0, 0, 'h010);
        for (int i = 0; i < 5; i++) step("ovf_call", 0, 1, 0, 1, 0, 0, 1, 0);
        chk("plan.ovf_flag", 32'(Stk_Ovf), 32'd1);
        chk("plan.ovf_depth", 32'(Depth), 32'd4);
        for (int i = 0; i < 4; i++) begin
            step("ovf_ret", 1, 0, 0, 0, 0, 0, 0, 0);
            chk("plan.ovf_ret", 32'(PC), 32'(32'h15 - i));
        end
        step("clr_ovf", 0, 0, 0, 0, 0, 1, 0, 0);
        chk("plan.ovf_clr", 32'(Stk_Ovf), 32'd0);

        // Underflow, clear, and set-beats-clear
        step("unf_ret", 1, 0, 0, 0, 0, 0, 0, 0);
        chk("plan.unf_pc", 32'(PC), 32'(RV));
        chk("plan.unf_flag", 32'(Stk_Unf), 32'd1);
        step("unf_clr", 0, 0, 0, 0, 0, 1, 0, 0);
        chk("plan.unf_clr", 32'(Stk_Unf), 32'd0);
        step("unf_clr_set", 1, 0, 0, 0, 0, 1, 0, 0);
        chk("plan.unf_set_wins", 32'(Stk_Unf), 32'd1);

        // Call and Ret together: Ret wins, no push
        step("aj_054", 0, 0, 1, 0, 0, 0, 0, 'h054);
        step("call_055", 0, 1, 1, 0, 0, 0, 0, 'h300);
        chk("plan.top_055", 32'(Top), 32'h055);
        step("call_ret", 1, 1, 1, 0, 0, 0, 0, 'h300);
        chk("plan.callret_pc", 32'(PC), 32'h055);
        chk("plan.callret_depth", 32'(Depth), 32'd0);

        // Asynchronous reset in the middle of a cycle
        step("pre_rst", 0, 1, 1, 0, 0, 0, 0, 'h321);
        idle("pre_rst2");
        #2;
        Reset = 1'b1;
        #1;
        chk("arst.pc", 32'(PC), 32'(RV));
        chk("arst.depth", 32'(Depth), 32'd0);
        chk("arst.npc", 32'(NPC), 32'(RV + 1));
        @(posedge Clk);
        #1;
        chk("arst.hold_pc", 32'(PC), 32'(RV));
        Reset = 1'b0;
        model_reset();
        check_state("arst");

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            step("rnd",
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0,
                 int'($urandom_range(0, MASK)),
                 int'($urandom_range(0, MASK)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
